// File: rtl/stack_controller.sv
// stack_controller: multi-cycle fetch/decode/execute sequencer for the
// 8-bit stack-machine datapath. Opcode in instruction[7:5].
// Optional feature macro: STACK_CTRL_ICOUNT_EN adds the retired-instruction
// counter and its icount port.
module stack_controller #(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       instruction,
    input  logic             z,
    output logic             ld_pc,
    output logic             pc_src,
    output logic             ld_B,
    output logic             stack_src,
    output logic             push_sig,
    output logic             pop_sig,
    output logic             tos_sig,
    output logic             mem_write_sig,
    output logic [1:0]       alu_op
`ifdef STACK_CTRL_ICOUNT_EN
    ,
    output logic [CNT_W-1:0] icount
`endif
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_POP_A,
        S_POP_B,
        S_POP_N,
        S_WB,
        S_PUSH,
        S_POP_M,
        S_JZ_T,
        S_JZ_B
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_PUSH = OP_W'(4);
    localparam logic [OP_W-1:0] OP_POP  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JZ   = OP_W'(7);

    state_t          state_q;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] dec_op;

    // The jump target bits are consumed by the datapath PC mux, not here.
    logic unused_operand;
    assign unused_operand = ^instruction[4:0];

    assign dec_op = instruction[7 -: OP_W];

    // Sequencer: state register plus opcode latch taken in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= dec_op;
                    case (dec_op)
                        OP_ADD, OP_SUB, OP_AND: state_q <= S_POP_A;
                        OP_NOT:                 state_q <= S_POP_N;
                        OP_PUSH:                state_q <= S_PUSH;
                        OP_POP:                 state_q <= S_POP_M;
                        OP_JMP:                 state_q <= S_FETCH;
                        OP_JZ:                  state_q <= S_JZ_T;
                        default:                state_q <= S_FETCH;
                    endcase
                end
                S_POP_A:  state_q <= S_POP_B;
                S_POP_B:  state_q <= S_WB;
                S_POP_N:  state_q <= S_WB;
                S_JZ_T:   state_q <= S_JZ_B;
                default:  state_q <= S_FETCH;  // WB, PUSH, POP_M, JZ_B retire
            endcase
        end
    end

    // Control decode from state; everything is gated off while rst is high
    // so a reset mid-instruction can never leak a push, pop or write.
    // JZ_B reads z live because the datapath only updates it at the JZ_T edge.
    always_comb begin
        ld_pc         = 1'b0;
        pc_src        = 1'b0;
        ld_B          = 1'b0;
        stack_src     = 1'b0;
        push_sig      = 1'b0;
        pop_sig       = 1'b0;
        tos_sig       = 1'b0;
        mem_write_sig = 1'b0;
        alu_op        = 2'b00;
        if (!rst) begin
            alu_op = op_q[2] ? 2'b00 : op_q[1:0];
            case (state_q)
                S_DECODE: begin
                    if (dec_op == OP_JMP) begin
                        ld_pc  = 1'b1;
                        pc_src = 1'b1;
                    end
                end
                S_POP_A: begin
                    tos_sig = 1'b1;
                    ld_B    = 1'b1;
                    pop_sig = 1'b1;
                end
                S_POP_B, S_POP_N: begin
                    tos_sig = 1'b1;
                    pop_sig = 1'b1;
                end
                S_WB: begin
                    stack_src = 1'b1;
                    push_sig  = 1'b1;
                    ld_pc     = 1'b1;
                end
                S_PUSH: begin
                    push_sig = 1'b1;
                    ld_pc    = 1'b1;
                end
                S_POP_M: begin
                    tos_sig       = 1'b1;
                    mem_write_sig = 1'b1;
                    pop_sig       = 1'b1;
                    ld_pc         = 1'b1;
                end
                S_JZ_T: tos_sig = 1'b1;
                S_JZ_B: begin
                    ld_pc  = 1'b1;
                    pc_src = z;
                end
                default: ;
            endcase
        end
    end

`ifdef STACK_CTRL_ICOUNT_EN
    logic [CNT_W-1:0] icount_q;

    // Retired-instruction counter: one tick per ld_pc cycle, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            icount_q <= '0;
        end else if (ld_pc) begin
            icount_q <= icount_q + 1'b1;
        end
    end

    assign icount = icount_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: walks each opcode class cycle by
// cycle and checks the packed control word against hand-derived values.
// Control word: {ld_pc, pc_src, ld_B, stack_src, push, pop, tos, mem_wr, alu_op[1:0]}
module tb_stack_controller;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic       z;
    logic       ld_pc, pc_src, ld_B, stack_src, push_sig, pop_sig, tos_sig, mem_write_sig;
    logic [1:0] alu_op;
`ifdef STACK_CTRL_ICOUNT_EN
    logic [15:0] icount;
`endif

    int total;
    int bad;

    stack_controller dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .z            (z),
        .ld_pc        (ld_pc),
        .pc_src       (pc_src),
        .ld_B         (ld_B),
        .stack_src    (stack_src),
        .push_sig     (push_sig),
        .pop_sig      (pop_sig),
        .tos_sig      (tos_sig),
        .mem_write_sig(mem_write_sig),
        .alu_op       (alu_op)
`ifdef STACK_CTRL_ICOUNT_EN
        ,
        .icount       (icount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] outs;
    assign outs = {ld_pc, pc_src, ld_B, stack_src, push_sig, pop_sig,
                   tos_sig, mem_write_sig, alu_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and check the control word just after the edge.
    task automatic step(input string tag, input logic [9:0] exp);
        @(posedge clk);
        #1;
        check(tag, {22'd0, outs}, {22'd0, exp});
    endtask

    task automatic check_icount(input string tag, input int exp);
`ifdef STACK_CTRL_ICOUNT_EN
        check(tag, {16'd0, icount}, exp[31:0]);
`else
        if (exp < 0) $display("icount %s not built", tag);
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        instruction = 8'h00;
        z           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {22'd0, outs}, 32'd0);
        check_icount("reset_icount", 0);
        rst = 1'b0;
        check("fetch_after_reset", {22'd0, outs}, 32'd0);
        $display("txn reset");

        // JMP 9
        instruction = 8'hC9;
        step("jmp_decode", 10'b11_0000_0000);
        step("jmp_fetch",  10'b00_0000_0000);
        check_icount("jmp_icount", 1);
        $display("txn JMP 9");

        // ADD
        instruction = 8'h00;
        step("add_decode", 10'b00_0000_0000);
        step("add_pop_a",  10'b00_1001_1000);
        step("add_pop_b",  10'b00_0001_1000);
        step("add_wb",     10'b10_0110_0000);
        step("add_fetch",  10'b00_0000_0000);
        check_icount("add_icount", 2);
        $display("txn ADD");

        // JZ 4 taken
        instruction = 8'hE4;
        z = 1'b1;
        step("jz1_decode", 10'b00_0000_0000);
        step("jz1_t",      10'b00_0000_1000);
        step("jz1_b",      10'b11_0000_0000);
        step("jz1_fetch",  10'b00_0000_0000);
        check_icount("jz1_icount", 3);
        $display("txn JZ 4 z=1");

        // JZ 4 not taken
        z = 1'b0;
        step("jz0_decode", 10'b00_0000_0000);
        step("jz0_t",      10'b00_0000_1000);
        step("jz0_b",      10'b10_0000_0000);
        step("jz0_fetch",  10'b00_0000_0000);
        check_icount("jz0_icount", 4);
        $display("txn JZ 4 z=0");

        // POP to memory
        instruction = 8'hA3;
        step("pop_decode", 10'b00_0000_0000);
        step("pop_m",      10'b10_0001_1100);
        step("pop_fetch",  10'b00_0000_0000);
        check_icount("pop_icount", 5);
        $display("txn POP");

        // PUSH mdr
        instruction = 8'h80;
        step("push_decode", 10'b00_0000_0000);
        step("push_exec",   10'b10_0010_0000);
        step("push_fetch",  10'b00_0000_0000);
        check_icount("push_icount", 6);
        $display("txn PUSH");

        // NOT: alu_op 11 persists into the following FETCH since op_q is held
        instruction = 8'h60;
        step("not_decode", 10'b00_0000_0000);
        step("not_pop_n",  10'b00_0001_1011);
        step("not_wb",     10'b10_0110_0011);
        step("not_fetch",  10'b00_0000_0011);
        check_icount("not_icount", 7);
        $display("txn NOT");

        // SUB interrupted by reset in POP_B
        instruction = 8'h20;
        step("sub_decode", 10'b00_0000_0011);
        step("sub_pop_a",  10'b00_1001_1001);
        step("sub_pop_b",  10'b00_0001_1001);
        rst = 1'b1;
        #1;
        check("sub_rst_gate", {22'd0, outs}, 32'd0);
        step("sub_rst_edge", 10'b00_0000_0000);
        check_icount("sub_rst_icount", 0);
        rst = 1'b0;
        check("sub_rst_fetch", {22'd0, outs}, 32'd0);
        $display("txn SUB reset in POP_B");

        // Recovery: a JMP executes normally from FETCH
        instruction = 8'hC9;
        step("rec_decode", 10'b11_0000_0000);
        step("rec_fetch",  10'b00_0000_0000);
        check_icount("rec_icount", 1);
        $display("txn JMP after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
# stack_controller

Multi-cycle control unit for the 8-bit stack-machine datapath. It consumes the registered `instruction` word and the `z` flag produced by `DataPath`, and drives that block's load, stack, memory-write, PC-select and ALU-op controls. It sequences fetch, decode and execute for the eight-opcode instruction set. It is the controller half of the CPU and connects port-for-port to `DataPath`.

## Interface
Parameters:
- `OP_W`, default 3: opcode width, taken from `instruction[7:5]`.
- `CNT_W`, default 16: retired-instruction counter width. Used only with `STACK_CTRL_ICOUNT_EN`.

Ports:
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `instruction`, in, 8: registered instruction word from the datapath.
- `z`, in, 1: registered top-of-stack-is-zero flag.
- `ld_pc`, out, 1: PC load enable.
- `pc_src`, out, 1: PC source. 0 selects pc+1; 1 selects `instruction[4:0]`.
- `ld_B`, out, 1: load B register from stack output.
- `stack_src`, out, 1: stack write-data select. 0 selects mdr; 1 selects the ALU result register.
- `push_sig`, out, 1: stack push.
- `pop_sig`, out, 1: stack pop.
- `tos_sig`, out, 1: drive the stack top onto `stack_out`.
- `mem_write_sig`, out, 1: data memory write of `stack_out` at the current address.
- `alu_op`, out, 2: ALU function. 00 is add, 01 is sub, 10 is and, 11 is not.
- `icount`, out, `CNT_W`: retired-instruction count. Present only with `STACK_CTRL_ICOUNT_EN`.

## Operation
Opcodes are taken from `instruction[7:5]`:
- 000 ADD, 001 SUB, 010 AND, 011 NOT.
- 100 PUSH: push mdr.
- 101 POP: pop the top and write it to memory.
- 110 JMP.
- 111 JZ.

Opcode handling:
- The opcode is latched into `op_q` in DECODE. It is held until the next DECODE.
- `alu_op` equals `op_q[1:0]` when `op_q[2]` is 0, otherwise 00.

Outputs are decoded from state, `op_q` and `z`. Any output not listed for a state is 0.

State transitions:
- FETCH: no outputs → DECODE.
- DECODE:
  - ADD, SUB, AND → POP_A.
  - NOT → POP_N.
  - PUSH → PUSH.
  - POP → POP_M.
  - JMP: `ld_pc`=1, `pc_src`=1 → FETCH.
  - JZ → JZ_T.
- POP_A: `tos_sig`, `ld_B`, `pop_sig` → POP_B.
- POP_B: `tos_sig`, `pop_sig`; the ALU result register captures B op top → WB.
- POP_N: `tos_sig`, `pop_sig` → WB.
- WB: `stack_src`=1, `push_sig`, `ld_pc`, `pc_src`=0 → FETCH.
- PUSH: `stack_src`=0, `push_sig`, `ld_pc`, `pc_src`=0 → FETCH.
- POP_M: `tos_sig`, `mem_write_sig`, `pop_sig`, `ld_pc`, `pc_src`=0 → FETCH.
- JZ_T: `tos_sig`; `z` registers at this edge → JZ_B.
- JZ_B: `ld_pc`, `pc_src`=`z` → FETCH. No pop.

An instruction retires in the cycle in which it asserts `ld_pc`.

## Timing
- Reset:
  - `rst` high at a rising edge forces FETCH and clears `op_q`.
  - While `rst` is high, every output is forced to 0, combinationally gated. No push, pop or write can occur during reset.
  - `icount` resets to 0.
- Reset mid-instruction: the instruction is abandoned. Execution restarts at FETCH from the current datapath PC. No partial stack effects are issued after the reset edge.
- Latency in cycles, from FETCH through the `ld_pc` cycle:
  - JMP: 2.
  - PUSH, POP: 3.
  - NOT, JZ: 4.
  - ADD, SUB, AND: 5.
- Every instruction asserts `ld_pc` for exactly one cycle. `push_sig` and `pop_sig` are never high in the same cycle.
- `z` is sampled only in JZ_B, one cycle after the `tos_sig` in JZ_T.
- `icount` increments by 1 on every `ld_pc` cycle and wraps from all-ones to 0.

## Configuration
- `STACK_CTRL_ICOUNT_EN`:
  - Defined: the `icount` port and its `CNT_W`-bit counter are compiled in.
  - Undefined: the port and counter are absent, and the FSM behaviour is identical.

## Test plan
- `rst`=1 for 2 cycles, then release: all outputs are 0 during reset, the state is FETCH, and `icount`=0.
- `instruction`=8'h00 (ADD): cycles 3–5 show `ld_B`+`pop_sig`, then `pop_sig`, then `push_sig`+`stack_src`=1+`ld_pc`, with `alu_op`=00 throughout. The next FETCH comes at cycle 6.
- `instruction`=8'hC9 (JMP 9): `ld_pc`=1 and `pc_src`=1 in cycle 2, back in FETCH in cycle 3, `icount`=1.
- `instruction`=8'hE4 (JZ 4): with `z`=1 in JZ_B, `pc_src`=1; repeat with `z`=0, `pc_src`=0. `pop_sig` stays 0 in both cases.
- `instruction`=8'hA3 (POP): POP_M asserts `mem_write_sig`, `pop_sig` and `ld_pc` together for exactly 1 cycle.
- Assert `rst` during POP_B of a SUB: no WB push occurs, FETCH follows the reset edge, and outputs are 0 in the reset cycle.
